mvu_pe_popcount_acc: RTL

Pipelined, parametrised popcount-and-accumulate unit for the binary (1-bit) datapath of the MVU processing element. Each accepted beat is SIMD 1-bit SIMD products. The block reduces them through a registered adder tree and accumulates SF consecutive beats (one synapse fold) into one dot-product result. A global enable freezes the pipeline for stalls. Optional bipolar conversion turns the popcount into a ±1 dot product.

---
 rtl/mvu_pe_popcount_acc.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mvu_pe_popcount_acc.sv
// Binary popcount-and-accumulate stage of the MVU processing element.
// Define MVU_POPCOUNT_BIPOLAR_EN to emit the signed +/-1 dot product instead of the raw popcount.
module mvu_pe_popcount_acc #(
    parameter int unsigned SIMD = 8,
    parameter int unsigned SF   = 4,
`ifdef MVU_POPCOUNT_BIPOLAR_EN
    localparam int unsigned OUT_W = $clog2(SIMD * SF + 1) + 1
`else
    localparam int unsigned OUT_W = $clog2(SIMD * SF + 1)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_v,
    input  logic [SIMD-1:0]  in_simd,
    output logic             out_v,
    output logic [OUT_W-1:0] out_acc
);

    localparam int unsigned L     = $clog2(SIMD);
    localparam int unsigned ACC_W = $clog2(SIMD * SF + 1);
    localparam int unsigned TW    = $clog2(SIMD + 1);
    localparam int unsigned FW    = (SF > 1) ? $clog2(SF) : 1;

    // Number of elements at tree level k (level 0 is the registered input beat).
    function automatic int unsigned lvl_n(input int unsigned k);
        return (SIMD + (1 << k) - 1) >> k;
    endfunction

    // Bits that can be non-zero for a node one level above level k.
    function automatic logic [TW-1:0] lmask(input int unsigned k);
        logic [TW-1:0] m;
        for (int unsigned b = 0; b < TW; b++) begin
            m[b] = (b < k + 2);
        end
        return m;
    endfunction

    logic [SIMD-1:0] r0;
    logic            r0_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r0   <= '0;
            r0_v <= 1'b0;
        end else if (en) begin
            r0   <= in_simd;
            r0_v <= in_v;
        end
    end

    logic [TW-1:0] tree_out;
    logic          tree_v;

    generate
        if (L == 0) begin : g_notree
            assign tree_out = TW'(r0);
            assign tree_v   = r0_v;
        end else begin : g_tree
            logic [TW-1:0] lv [L][SIMD];
            logic [L-1:0]  lvv;

            // Node i of level k+1: sum of elements 2i and 2i+1 of level k, the
            // lone odd element simply passing through.
            function automatic logic [TW-1:0] node(input int unsigned k, input int unsigned i);
                logic [TW-1:0] s;
                s = '0;
                for (int unsigned j = 0; j < SIMD; j++) begin
                    if ((j >> 1) == i && j < lvl_n(k)) begin
                        if (k == 0)
                            s = s + TW'(r0[j]);
                        else
                            s = s + lv[(k == 0) ? 0 : k - 1][j];
                    end
                end
                return s & lmask(k);
            endfunction

            always_ff @(posedge clk) begin
                if (rst) begin
                    lvv <= '0;
                    for (int unsigned k = 0; k < L; k++) begin
                        for (int unsigned i = 0; i < SIMD; i++) begin
                            lv[k][i] <= '0;
                        end
                    end
                end else if (en) begin
                    for (int unsigned k = 0; k < L; k++) begin
                        lvv[k] <= (k == 0) ? r0_v : lvv[(k == 0) ? 0 : k - 1];
                        for (int unsigned i = 0; i < SIMD; i++) begin
                            lv[k][i] <= node(k, i);
                        end
                    end
                end
            end

            assign tree_out = lv[L-1][0];
            assign tree_v   = lvv[L-1];
        end
    endgenerate

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] tree_ext;
    logic [ACC_W-1:0] sum;
    logic [FW-1:0]    fcnt;

    assign tree_ext = ACC_W'(tree_out);

    // A fold's first beat loads rather than adds, so back-to-back folds need no clear cycle.
    always_comb begin
        sum = (fcnt == '0) ? tree_ext : acc + tree_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt    <= '0;
            acc     <= '0;
            out_v   <= 1'b0;
            out_acc <= '0;
        end else if (en) begin
            out_v <= 1'b0;
            if (tree_v) begin
                acc <= sum;
                if (fcnt == FW'(SF - 1)) begin
                    fcnt  <= '0;
                    out_v <= 1'b1;
`ifdef MVU_POPCOUNT_BIPOLAR_EN
                    out_acc <= OUT_W'({sum, 1'b0}) - OUT_W'(SIMD * SF);
`else
                    out_acc <= sum;
`endif
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

endmodule
